// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes,
// ALUop codes and datapath mux selects.
package multicycle_main_control_pkg;

    // 12 states packed into 4 bits
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBeq      = 4'd8,
        StJump     = 4'd9,
        StIExec    = 4'd10,
        StIWb      = 4'd11
    } state_e;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // ALUop pair handed to ALUcontrol
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch target out of DECODE; unknown opcodes fall back to FETCH
    function automatic state_e decode_next(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_RTYPE:                  nxt = StRExec;
            OP_LW, OP_SW:              nxt = StMemAddr;
            OP_BEQ:                    nxt = StBeq;
            OP_J:                      nxt = StJump;
            OP_ADDI, OP_ANDI, OP_ORI:  nxt = StIExec;
            default:                   nxt = StFetch;
        endcase
        return nxt;
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return decode_next(op) != StFetch;
    endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Moore main-control FSM for the multicycle MIPS datapath. Drives datapath
// enables and the ALUop pair, and counts retired instructions.
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSource,
    output logic                 ALUop1,
    output logic                 ALUop0,
    output logic                 illegal_op,
    output logic                 instr_done,
    output logic [CNT_WIDTH-1:0] retired
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q;
    logic [1:0]           alu_op;

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                retired_q <= retired_q + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state and output decode; reset forces every output low
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        alu_op      = ALUOP_ADD;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;

        unique case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ALUSrcB    = SRCB_IMM_SH;
                illegal_op = !is_legal_op(opcode);
                state_d    = decode_next(opcode);
            end
            StMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LW) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StRExec: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                state_d = StRWb;
            end
            StRWb: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBeq: begin
                ALUSrcA     = 1'b1;
                alu_op      = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                state_d     = StFetch;
            end
            StJump: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StIExec: begin
                // ALUcontrol picks the I-type op from the opcode itself
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = StIWb;
            end
            StIWb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset aborts any in-flight instruction without side effects
        if (reset) begin
            state_d     = StFetch;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SRCB_REG;
            PCSource    = PCSRC_ALU;
            alu_op      = ALUOP_ADD;
            illegal_op  = 1'b0;
            instr_done  = 1'b0;
        end
    end

    assign ALUop1  = alu_op[1];
    assign ALUop0  = alu_op[0];
    assign retired = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: walks each instruction class
// cycle by cycle and compares the full control word against hand vectors.
module tb_multicycle_main_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA, ALUop1, ALUop0;
    logic        illegal_op, instr_done;
    logic [1:0]  ALUSrcB, PCSource;
    logic [31:0] retired;

    // Narrow-counter instance used to observe the wrap of retired
    logic        n_pcw, n_pcwc, n_iord, n_mr, n_mw, n_irw, n_m2r, n_rd, n_rw, n_srca;
    logic        n_op1, n_op0, n_ill, n_done;
    logic [1:0]  n_srcb, n_pcs;
    logic [1:0]  n_retired;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(.CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUop1(ALUop1), .ALUop0(ALUop0), .illegal_op(illegal_op), .instr_done(instr_done),
        .retired(retired)
    );

    multicycle_main_control #(.CNT_WIDTH(2)) u_dut_narrow (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(n_pcw), .PCWriteCond(n_pcwc), .IorD(n_iord), .MemRead(n_mr),
        .MemWrite(n_mw), .IRWrite(n_irw), .MemtoReg(n_m2r), .RegDst(n_rd),
        .RegWrite(n_rw), .ALUSrcA(n_srca), .ALUSrcB(n_srcb), .PCSource(n_pcs),
        .ALUop1(n_op1), .ALUop0(n_op0), .illegal_op(n_ill), .instr_done(n_done),
        .retired(n_retired)
    );

    // Control word: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    // RegDst RegWrite ALUSrcA ALUSrcB[1:0] PCSource[1:0] ALUop[1:0] illegal_op instr_done
    logic [17:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop1, ALUop0,
                   illegal_op, instr_done};

    localparam logic [17:0] V_ZERO    = 18'b0;
    localparam logic [17:0] V_FETCH   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] V_FWAIT   = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] V_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] V_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [17:0] V_ADDR    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] V_MREAD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_MWB     = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
    localparam logic [17:0] V_MWWAIT  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_MWDONE  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
    localparam logic [17:0] V_REXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
    localparam logic [17:0] V_RWB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
    localparam logic [17:0] V_BEQ     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
    localparam logic [17:0] V_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_10_00_0_1;
    localparam logic [17:0] V_IEXEC   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] V_IWB     = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs at a falling edge, check the control word, advance one cycle
    task automatic step(input string tag, input logic [5:0] op, input logic rdy,
                        input logic [17:0] exp);
        opcode    = op;
        mem_ready = rdy;
        #1;
        check_eq(tag, {14'b0, ctrl}, {14'b0, exp});
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_ctrl", {14'b0, ctrl}, {14'b0, V_ZERO});
        check_eq("reset_retired", retired, 32'd0);
        @(negedge clk);

        // 1: reset asserted for two cycles while stalled in MEM_WRITE
        reset = 1'b0;
        step("t1_fetch", 6'b101011, 1'b1, V_FETCH);
        step("t1_decode", 6'b101011, 1'b1, V_DECODE);
        step("t1_addr", 6'b101011, 1'b1, V_ADDR);
        step("t1_mw_wait", 6'b101011, 1'b0, V_MWWAIT);
        reset = 1'b1;
        step("t1_rst_c0", 6'b101011, 1'b1, V_ZERO);
        step("t1_rst_c1", 6'b101011, 1'b1, V_ZERO);
        reset = 1'b0;
        #1;
        check_eq("t1_retired", retired, 32'd0);
        step("t1_fetch_after", 6'b000000, 1'b0, V_FWAIT);

        // 2: R-type, 4 cycles
        step("t2_fetch", 6'b000000, 1'b1, V_FETCH);
        step("t2_decode", 6'b000000, 1'b1, V_DECODE);
        step("t2_rexec", 6'b000000, 1'b1, V_REXEC);
        step("t2_rwb", 6'b000000, 1'b1, V_RWB);
        check_eq("t2_retired", retired, 32'd1);

        // 3: lw with three stall cycles in MEM_READ; mem_ready=0 in DECODE is ignored
        step("t3_fetch", 6'b100011, 1'b1, V_FETCH);
        step("t3_decode", 6'b100011, 1'b0, V_DECODE);
        step("t3_addr", 6'b100011, 1'b1, V_ADDR);
        for (int i = 0; i < 3; i++) begin
            step("t3_mr_wait", 6'b100011, 1'b0, V_MREAD);
        end
        step("t3_mr_done", 6'b100011, 1'b1, V_MREAD);
        step("t3_mwb", 6'b100011, 1'b1, V_MWB);
        check_eq("t3_retired", retired, 32'd2);

        // 4: beq, back in FETCH on the 4th cycle
        step("t4_fetch", 6'b000100, 1'b1, V_FETCH);
        step("t4_decode", 6'b000100, 1'b1, V_DECODE);
        step("t4_beq", 6'b000100, 1'b1, V_BEQ);
        step("t4_fetch_again", 6'b000100, 1'b0, V_FWAIT);
        check_eq("t4_retired", retired, 32'd3);
        check_eq("t4_narrow_full", {30'b0, n_retired}, 32'd3);

        // 5: ori; narrow counter wraps from all-ones to 0
        step("t5_fetch", 6'b001101, 1'b1, V_FETCH);
        step("t5_decode", 6'b001101, 1'b1, V_DECODE);
        step("t5_iexec", 6'b001101, 1'b1, V_IEXEC);
        step("t5_iwb", 6'b001101, 1'b1, V_IWB);
        check_eq("t5_retired", retired, 32'd4);
        check_eq("t5_narrow_wrap", {30'b0, n_retired}, 32'd0);

        // 6: illegal opcode, not retired
        step("t6_fetch", 6'b111111, 1'b1, V_FETCH);
        step("t6_decode", 6'b111111, 1'b1, V_DEC_ILL);
        step("t6_fetch_next", 6'b111111, 1'b0, V_FWAIT);
        check_eq("t6_retired", retired, 32'd4);

        // jump, then a full sw with no stall
        step("j_fetch", 6'b000010, 1'b1, V_FETCH);
        step("j_decode", 6'b000010, 1'b1, V_DECODE);
        step("j_jump", 6'b000010, 1'b1, V_JUMP);
        step("sw_fetch", 6'b101011, 1'b1, V_FETCH);
        step("sw_decode", 6'b101011, 1'b1, V_DECODE);
        step("sw_addr", 6'b101011, 1'b1, V_ADDR);
        step("sw_mw_done", 6'b101011, 1'b1, V_MWDONE);
        step("sw_fetch_next", 6'b000000, 1'b0, V_FWAIT);
        check_eq("final_retired", retired, 32'd6);
        check_eq("final_narrow", {30'b0, n_retired}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
